// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
// Wrapper stage around the registered carry-lookahead adder. Operands A and B
// arrive as narrow beats (least-significant first) and are assembled onto the
// adder inputs. The sequencer then waits out the adder's register latency,
// captures sum/carry into a result register, and holds it until the consumer
// takes it. One addition is in flight at a time.
// Optional feature: define ADDER_SIGNED_OVF_EN to add the res_ovf output
// (two's-complement overflow of the captured result).

module adder_operand_sequencer #(
  parameter int W     = 64,
  parameter int BUS_W = 16,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_sum,
  input  logic             add_carry,
  output logic [W-1:0]     res_sum,
  output logic             res_carry,
`ifdef ADDER_SIGNED_OVF_EN
  output logic             res_ovf,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int NB = W / BUS_W;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [BW-1:0]   beat_cnt;
  logic [CW-1:0]   wait_cnt;
  logic            beat_fire;
  logic            last_beat;
  logic            wait_done;

  assign beat_fire = in_valid && in_ready;
  assign last_beat = (beat_cnt == BW'(NB - 1));
  assign wait_done = (wait_cnt == CW'(LAT));

  // State register; busy is registered alongside so it changes with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD_A;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_WAIT) || (state_next == ST_HOLD);
    end
  end

  // Next-state: load A, load B, wait for the adder, then hold until taken.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD_A: if (beat_fire && last_beat) state_next = ST_LOAD_B;
      ST_LOAD_B: if (beat_fire && last_beat) state_next = ST_WAIT;
      ST_WAIT:   if (wait_done)              state_next = ST_HOLD;
      ST_HOLD:   if (res_ready)              state_next = ST_LOAD_A;
      default:                               state_next = ST_LOAD_A;
    endcase
  end

  // Beats are accepted only while loading, and never while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && ((state == ST_LOAD_A) || (state == ST_LOAD_B))) begin
      in_ready = 1'b1;
    end
  end

  // Beat counter selects the operand slice; it wraps after each full operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (beat_fire) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // Wait counter runs only in WAIT, so it always enters WAIT at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Operand registers are written one slice per beat and otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a <= '0;
      add_b <= '0;
    end else if (beat_fire) begin
      if (state == ST_LOAD_A) begin
        add_a[beat_cnt*BUS_W +: BUS_W] <= in_data;
      end else begin
        add_b[beat_cnt*BUS_W +: BUS_W] <= in_data;
      end
    end
  end

  // Result register: capture once the adder output has settled, drop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_valid <= 1'b0;
`ifdef ADDER_SIGNED_OVF_EN
      res_ovf   <= 1'b0;
`endif
    end else if ((state == ST_WAIT) && wait_done) begin
      res_sum   <= add_sum;
      res_carry <= add_carry;
      res_valid <= 1'b1;
`ifdef ADDER_SIGNED_OVF_EN
      res_ovf   <= (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
`endif
    end else if ((state == ST_HOLD) && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// tb_adder_operand_sequencer
// Drives operand beats into the sequencer, stands in for the registered adder,
// and compares every output against a transaction-level model each cycle.
// Build with ADDER_SIGNED_OVF_EN defined to include the overflow output.

module tb_adder_operand_sequencer;

  localparam int W     = 64;
  localparam int BUS_W = 16;
  localparam int LAT   = 2;
  localparam int NB    = W / BUS_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [BUS_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_sum;
  logic             add_carry;
  logic [W-1:0]     res_sum;
  logic             res_carry;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
`ifdef ADDER_SIGNED_OVF_EN
  logic             res_ovf;
`endif

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  // Model state: operands seen so far, beat count, and the result it implies.
  logic [W-1:0] m_a, m_b, m_sum;
  logic         m_carry, m_ovf, m_valid;
  int           m_beats, m_edge, m_last;

  always #5 clk = ~clk;

  adder_operand_sequencer #(.W(W), .BUS_W(BUS_W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .res_sum   (res_sum),
    .res_carry (res_carry),
`ifdef ADDER_SIGNED_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  // Stand-in for the adder: an unreset LAT-stage pipeline of a+b.
  logic [W:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {add_carry, add_sum} = pipe[LAT-1];

  // Reference model: 2*NB accepted beats fill A then B; the result appears
  // LAT+1 edges after the last beat and is released by a handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_sum = '0; m_carry = 1'b0; m_ovf = 1'b0;
      m_valid = 1'b0; m_beats = 0; m_edge = 0; m_last = 0;
    end else begin
      m_edge++;
      if (m_beats < 2*NB) begin
        if (in_valid) begin
          if (m_beats < NB) m_a[m_beats*BUS_W +: BUS_W] = in_data;
          else              m_b[(m_beats-NB)*BUS_W +: BUS_W] = in_data;
          m_beats++;
          if (m_beats == 2*NB) m_last = m_edge;
        end
      end else if (!m_valid) begin
        if (m_edge == m_last + LAT + 1) begin
          {m_carry, m_sum} = {1'b0, m_a} + {1'b0, m_b};
          m_ovf   = (m_a[W-1] == m_b[W-1]) && (m_sum[W-1] != m_a[W-1]);
          m_valid = 1'b1;
        end
      end else if (res_ready) begin
        m_valid = 1'b0;
        m_beats = 0;
      end
    end
  end

  task automatic check_output(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (!done) begin
      check_output("in_ready",  W'(in_ready),  W'(rst_n && (m_beats < 2*NB)));
      check_output("busy",      W'(busy),      W'(m_beats == 2*NB));
      check_output("res_valid", W'(res_valid), W'(m_valid));
      check_output("add_a",     add_a,         m_a);
      check_output("add_b",     add_b,         m_b);
      check_output("res_sum",   res_sum,       m_sum);
      check_output("res_carry", W'(res_carry), W'(m_carry));
`ifdef ADDER_SIGNED_OVF_EN
      check_output("res_ovf",   W'(res_ovf),   W'(m_ovf));
`endif
    end
  end

  // Sends A then B beat by beat; gap<0 means a random 0..2 idle cycles per beat.
  // Returns the number of edges from the last B beat to res_valid (-1 on timeout).
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input int gap, output int lat);
    logic [2*W-1:0] ab;
    int g;
    ab = {b, a};
    for (int i = 0; i < 2*NB; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = ab[i*BUS_W +: BUS_W];
      if (i < 2*NB-1) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int j = 0; j < g; j++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = BUS_W'($urandom);
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = BUS_W'($urandom);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  // Keeps the result waiting for 'hold' cycles, then takes it.
  task automatic release_result(input int hold, input logic [W-1:0] exp_sum);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_output("hold_valid",    W'(res_valid), W'(1));
      check_output("hold_busy",     W'(busy),      W'(1));
      check_output("hold_in_ready", W'(in_ready),  W'(0));
      check_output("hold_sum",      res_sum,       exp_sum);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check_output("post_valid",    W'(res_valid), W'(0));
    check_output("post_in_ready", W'(in_ready),  W'(1));
  endtask

  initial begin
    int lat;
    logic [W-1:0] a, b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_output("rst_in_ready", W'(in_ready),  W'(0));
    check_output("rst_valid",    W'(res_valid), W'(0));
    check_output("rst_sum",      res_sum,       W'(0));
    check_output("rst_add_a",    add_a,         W'(0));
    rst_n = 1'b1;

    $display("[TB] 1 + 1, continuous beats");
    apply_stimulus(64'h1, 64'h1, 0, lat);
    check_output("t1_latency", W'(lat),       W'(3));
    check_output("t1_sum",     res_sum,       64'h2);
    check_output("t1_carry",   W'(res_carry), W'(0));
    release_result(0, 64'h2);

    $display("[TB] all-ones + 1");
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, lat);
    check_output("t2_sum",   res_sum,       64'h0);
    check_output("t2_carry", W'(res_carry), W'(1));
`ifdef ADDER_SIGNED_OVF_EN
    check_output("t2_ovf",   W'(res_ovf),   W'(0));
`endif
    release_result(0, 64'h0);

    $display("[TB] gapped beats, then 5-cycle hold");
    apply_stimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2, lat);
    check_output("t3_latency", W'(lat),       W'(3));
    check_output("t3_sum",     res_sum,       64'h2222_2222_2222_2211);
    check_output("t3_carry",   W'(res_carry), W'(0));
    release_result(5, 64'h2222_2222_2222_2211);

    $display("[TB] reset after two A beats");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    @(negedge clk);
    in_data  = 16'h5555;
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_output("mid_rst_add_a",    add_a,         W'(0));
    check_output("mid_rst_in_ready", W'(in_ready),  W'(0));
    check_output("mid_rst_busy",     W'(busy),      W'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply_stimulus(64'h5, 64'h7, 0, lat);
    check_output("t5_sum", res_sum, 64'hC);
    release_result(1, 64'hC);

`ifdef ADDER_SIGNED_OVF_EN
    $display("[TB] signed overflow");
    apply_stimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, lat);
    check_output("t6_sum",   res_sum,       64'h8000_0000_0000_0000);
    check_output("t6_ovf",   W'(res_ovf),   W'(1));
    check_output("t6_carry", W'(res_carry), W'(0));
    release_result(0, 64'h8000_0000_0000_0000);
`endif

    $display("[TB] randomized operations");
    for (int n = 0; n < 30; n++) begin
      bit early;
      case ($urandom_range(0, 3))
        0:       a = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       a = 64'h7FFF_FFFF_FFFF_FFFF;
        default: a = {$urandom, $urandom};
      endcase
      b = {$urandom, $urandom};
      early = 1'($urandom_range(0, 1));
      res_ready = early;
      apply_stimulus(a, b, -1, lat);
      check_output("rnd_latency", W'(lat), W'(3));
      release_result(early ? 0 : int'($urandom_range(0, 3)), a + b);
    end

    repeat (2) @(posedge clk);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
